// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

    // Fetch FSM states.
    //   IDLE  : nothing outstanding, request pc next
    //   WAIT  : a live request is outstanding
    //   HOLD  : a fetched word is parked in the buffer while IF/ID stalls
    //   DRAIN : a request made stale by a redirect is still outstanding
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } if_state_t;

    // addi x0, x0, 0
    localparam logic [31:0] RV_NOP           = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Instruction addresses are word aligned; low bits are dropped.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_instr_buf.sv
// One-entry instruction/PC holding register. Captures a fetched word
// when IF/ID cannot accept it, and keeps it until the stage moves on.
module if_instr_buf (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        load_i,
    input  logic        clear_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        valid_o
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;

    // Next-state: load wins over clear; otherwise hold contents.
    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (load_i) begin
            instr_d = instr_i;
            pc_d    = pc_i;
            valid_d = 1'b1;
        end else if (clear_i) begin
            valid_d = 1'b0;
        end
    end

    // Only the valid bit is reset; the payload is qualified by it.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
        instr_q <= instr_d;
        pc_q    <= pc_d;
    end

    assign instr_o = instr_q;
    assign pc_o    = pc_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/if_fetch_unit.sv
// RV32I instruction-fetch stage: owns the PC, issues single-outstanding
// imem requests, presents PC/PC+4/instruction to IF/ID, honours stalls
// and EX redirects, and drops responses that a redirect made stale.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IF_IDWrite,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_PC,
    output logic [31:0] IF_PCplus4,
    output logic [31:0] IF_Instr,
    output logic        IF_valid
);

    if_state_t   state_q, state_d;
    logic [31:0] pc_q, pc_d;

    logic [31:0] tgt_pc;
    logic [31:0] pc_plus4;
    logic        req;
    logic [31:0] req_addr;
    logic        pres_valid;
    logic        buf_load;
    logic        buf_clear;
    logic [31:0] buf_instr;
    logic [31:0] buf_pc;
    logic        buf_valid;

    assign tgt_pc   = align_pc(redirect_pc);
    assign pc_plus4 = pc_q + 32'd4;

    if_instr_buf u_buf (
        .clk_i   (clk),
        .reset_i (reset),
        .load_i  (buf_load),
        .clear_i (buf_clear),
        .instr_i (imem_rdata),
        .pc_i    (pc_q),
        .instr_o (buf_instr),
        .pc_o    (buf_pc),
        .valid_o (buf_valid)
    );

    // FSM next-state, PC update and request generation; redirect first.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req        = 1'b0;
        req_addr   = pc_q;
        pres_valid = 1'b0;
        buf_load   = 1'b0;
        buf_clear  = 1'b0;
        unique case (state_q)
            IDLE: begin
                req     = 1'b1;
                state_d = WAIT;
                if (redirect) begin
                    pc_d     = tgt_pc;
                    req_addr = tgt_pc;
                end
            end
            WAIT: begin
                if (redirect) begin
                    pc_d = tgt_pc;
                    if (imem_rvalid) begin
                        req      = 1'b1;
                        req_addr = tgt_pc;
                    end else begin
                        // The in-flight response now belongs to a dead path.
                        state_d = DRAIN;
                    end
                end else if (imem_rvalid) begin
                    pres_valid = 1'b1;
                    if (IF_IDWrite) begin
                        pc_d     = pc_plus4;
                        req      = 1'b1;
                        req_addr = pc_plus4;
                    end else begin
                        buf_load = 1'b1;
                        state_d  = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d      = tgt_pc;
                    req       = 1'b1;
                    req_addr  = tgt_pc;
                    buf_clear = 1'b1;
                    state_d   = WAIT;
                end else begin
                    pres_valid = buf_valid;
                    if (IF_IDWrite) begin
                        pc_d      = pc_plus4;
                        req       = 1'b1;
                        req_addr  = pc_plus4;
                        buf_clear = 1'b1;
                        state_d   = WAIT;
                    end
                end
            end
            DRAIN: begin
                if (redirect) begin
                    pc_d     = tgt_pc;
                    req_addr = tgt_pc;
                end
                // Stale data is dropped; refetch from the current target.
                if (imem_rvalid) begin
                    req     = 1'b1;
                    state_d = WAIT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and PC registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Presentation to IF/ID: buffered word in HOLD, memory word in WAIT,
    // NOP bubble otherwise. Requests are suppressed while reset is held.
    always_comb begin
        imem_req  = req & ~reset;
        imem_addr = req_addr;
        IF_valid  = pres_valid;
        IF_PC     = pc_q;
        IF_Instr  = RV_NOP;
        if (pres_valid) begin
            if (state_q == HOLD) begin
                IF_PC    = buf_pc;
                IF_Instr = buf_instr;
            end else begin
                IF_Instr = imem_rdata;
            end
        end
        IF_PCplus4 = IF_PC + 32'd4;
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios followed by random traffic,
// with an instruction-memory responder and a program-order reference model.
module tb_if_fetch_unit;
    import if_pkg::*;

    localparam logic [31:0] RESET_PC = DEFAULT_RESET_PC;

    logic        clk = 1'b0;
    logic        reset;
    logic        IF_IDWrite;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] IF_PC;
    logic [31:0] IF_PCplus4;
    logic [31:0] IF_Instr;
    logic        IF_valid;

    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .IF_IDWrite  (IF_IDWrite),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .IF_PC       (IF_PC),
        .IF_PCplus4  (IF_PCplus4),
        .IF_Instr    (IF_Instr),
        .IF_valid    (IF_valid)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: next program-order PC, whether a word is being held
    // for IF/ID, and memory-side view of the outstanding request.
    logic [31:0] exp_pc;
    bit          held;
    bit          stale;
    bit          m_pend;
    int          m_cnt;
    logic [31:0] m_addr;
    int          lat;
    bit          prev_rst;
    bit          armed;
    int          idle_run;

    logic        o_req, o_valid;
    logic [31:0] o_addr, o_pc, o_p4, o_instr;

    // Instruction memory contents as a function of the address.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h1F2E};
    endfunction

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs and memory response, sample mid-cycle,
    // check against the model, then advance the model.
    task automatic cyc(input bit idw, input bit rd, input logic [31:0] rpc, input bit rst);
        logic [31:0] nxt;
        bit ev, er, rv;
        reset       = rst;
        IF_IDWrite  = idw;
        redirect    = rd;
        redirect_pc = rpc;
        rv          = m_pend && (m_cnt == 1);
        imem_rvalid = rv;
        imem_rdata  = rv ? memf(m_addr) : $urandom;
        @(negedge clk);
        o_req   = imem_req;
        o_addr  = imem_addr;
        o_valid = IF_valid;
        o_pc    = IF_PC;
        o_p4    = IF_PCplus4;
        o_instr = IF_Instr;
        if (rst) begin
            chk1("req_in_reset", o_req, 1'b0);
            exp_pc   = RESET_PC;
            held     = 0;
            stale    = 0;
            m_pend   = 0;
            prev_rst = 1;
            armed    = 1;
            idle_run = 0;
        end else if (armed) begin
            if (prev_rst) begin
                chk1 ("rstval_valid", o_valid, 1'b0);
                chk32("rstval_instr", o_instr, RV_NOP);
                chk32("rstval_pc",    o_pc,    RESET_PC);
                chk32("rstval_pc4",   o_p4,    RESET_PC + 32'd4);
            end
            ev  = !rd && (held || (rv && !stale));
            nxt = rd ? {rpc[31:2], 2'b00} : (ev && idw) ? exp_pc + 32'd4 : exp_pc;
            er  = (!m_pend || rv) && !(ev && !idw);
            chk1 ("valid", o_valid, ev);
            chk32("pc",    o_pc,    exp_pc);
            chk32("pc4",   o_p4,    exp_pc + 32'd4);
            chk32("instr", o_instr, ev ? memf(exp_pc) : RV_NOP);
            chk1 ("req",   o_req,   er);
            if (er) chk32("addr", o_addr, nxt);
            idle_run = ev ? 0 : idle_run + 1;
            total++;
            assert (idle_run <= 200) else begin
                bad++;
                $error("FAIL liveness observed=%0d idle cycles expected<=200", idle_run);
            end
            held = ev && !idw;
            if (rv) stale = 0;
            if (rd && m_pend && !rv) stale = 1;
            if (rv) m_pend = 0;
            else if (m_pend) m_cnt--;
            if (o_req) begin
                m_pend = 1;
                m_cnt  = lat;
                m_addr = o_addr;
                stale  = 0;
            end
            exp_pc   = nxt;
            prev_rst = 0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit found, seen10, reqseen;
        reset       = 1'b1;
        IF_IDWrite  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        exp_pc      = RESET_PC;
        held        = 0;
        stale       = 0;
        m_pend      = 0;
        m_cnt       = 0;
        m_addr      = 32'h0;
        lat         = 1;
        prev_rst    = 0;
        armed       = 0;
        idle_run    = 0;
        @(posedge clk);
        #1;

        // Reset then free-run with 1-cycle memory.
        cyc(0, 0, 32'h0, 1);
        cyc(0, 0, 32'h0, 1);
        cyc(1, 0, 32'h0, 0);
        chk1 ("first_req",  o_req,  1'b1);
        chk32("first_addr", o_addr, 32'h0);
        cyc(1, 0, 32'h0, 0);
        chk1 ("run_v0",     o_valid, 1'b1);
        chk32("run_pc0",    o_pc,    32'h0);
        chk32("run_addr4",  o_addr,  32'h4);
        cyc(1, 0, 32'h0, 0);
        chk32("run_pc4",    o_pc,    32'h4);
        chk32("run_addr8",  o_addr,  32'h8);

        // Stall for three cycles while 0x8 is presented.
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 32'h0, 0);
            chk1 ("stall_valid", o_valid, 1'b1);
            chk32("stall_pc",    o_pc,    32'h8);
            chk32("stall_pc4",   o_p4,    32'hC);
            chk32("stall_instr", o_instr, memf(32'h8));
            chk1 ("stall_noreq", o_req,   1'b0);
        end
        cyc(1, 0, 32'h0, 0);
        chk1 ("release_req",  o_req,  1'b1);
        chk32("release_addr", o_addr, 32'hC);

        // Park 0xC in HOLD, then redirect with nothing outstanding.
        cyc(0, 0, 32'h0, 0);
        chk32("hold_pc", o_pc, 32'hC);
        cyc(0, 1, 32'h103, 0);
        chk1 ("redir_req",   o_req,   1'b1);
        chk32("redir_addr",  o_addr,  32'h100);
        chk1 ("redir_valid", o_valid, 1'b0);
        lat = 3;
        cyc(1, 0, 32'h0, 0);
        chk1 ("tgt_valid", o_valid, 1'b1);
        chk32("tgt_pc",    o_pc,    32'h100);

        // Redirect one cycle after a request to 0x10 with 3-cycle memory.
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            cyc(0, 0, 32'h0, 0);
            found = o_valid;
        end
        chk1("hold_reached", found, 1'b1);
        cyc(0, 1, 32'h10, 0);
        chk32("req10_addr", o_addr, 32'h10);
        cyc(1, 1, 32'h200, 0);
        chk1("drain_noreq", o_req, 1'b0);
        found   = 0;
        seen10  = 0;
        reqseen = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc(1, 0, 32'h0, 0);
            if (o_valid && o_pc == 32'h10) seen10 = 1;
            if (o_req && !reqseen) begin
                reqseen = 1;
                chk32("drain_next_addr", o_addr, 32'h200);
            end
            if (o_valid) begin
                found = 1;
                chk32("drain_tgt_pc", o_pc, 32'h200);
            end
        end
        chk1("stale_never_valid", seen10, 1'b0);
        chk1("drain_tgt_seen",    found,  1'b1);

        // Wrap-around at the top of the address space.
        lat = 1;
        cyc(0, 1, 32'hFFFF_FFFC, 0);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc(0, 0, 32'h0, 0);
            found = o_valid;
        end
        chk1 ("wrap_seen", found, 1'b1);
        chk32("wrap_pc",   o_pc,  32'hFFFF_FFFC);
        chk32("wrap_pc4",  o_p4,  32'h0);
        cyc(1, 0, 32'h0, 0);
        chk1 ("wrap_req",  o_req,  1'b1);
        chk32("wrap_addr", o_addr, 32'h0);
        cyc(1, 0, 32'h0, 0);
        chk1 ("wrap_next_valid", o_valid, 1'b1);
        chk32("wrap_next_pc",    o_pc,    32'h0);

        // Reset while a fetch is in flight.
        lat = 3;
        cyc(1, 0, 32'h0, 0);
        cyc(1, 0, 32'h0, 0);
        cyc(1, 0, 32'h0, 1);
        cyc(1, 0, 32'h0, 1);
        cyc(1, 0, 32'h0, 0);
        chk1 ("midrst_req",  o_req,  1'b1);
        chk32("midrst_addr", o_addr, RESET_PC);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            bit          r_idw, r_rd, r_rst;
            logic [31:0] r_pc;
            if (n % 64 == 0) lat = $urandom_range(1, 4);
            r_idw = ($urandom_range(0, 99) < 70);
            r_rd  = ($urandom_range(0, 99) < 8);
            r_rst = ($urandom_range(0, 199) == 0);
            r_pc  = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                : 32'($urandom);
            cyc(r_idw, r_rd, r_pc, r_rst);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage of the RV32I pipeline. It owns the program counter, issues single-outstanding requests to instruction memory, and presents `IF_PC`, `IF_PCplus4` and `IF_Instr` to the IF/ID pipeline register. It honours the IF/ID stall (`IF_IDWrite`) and EX-stage redirects (taken branch or jump), and discards any in-flight fetch that a redirect makes stale.

## Interface

Parameters:
- `RESET_PC`, 32'h0000_0000: PC loaded on reset. Bits [1:0] must be 0.

Ports. One clock; reset is synchronous and active-high.
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `IF_IDWrite` in 1: IF/ID accepts the presented instruction at this edge. 0 = stall.
- `redirect` in 1: taken branch or jump from EX.
- `redirect_pc` in 32: target PC. Bits [1:0] are ignored and forced to 0.
- `imem_req` out 1: fetch request, a one-cycle pulse.
- `imem_addr` out 32: fetch address, valid while `imem_req`=1.
- `imem_rvalid` in 1: response valid. Arrives ≥1 cycle after `imem_req`.
- `imem_rdata` in 32: instruction word, valid with `imem_rvalid`.
- `IF_PC` out 32: PC of the presented instruction.
- `IF_PCplus4` out 32: `IF_PC`+4, modulo 2^32.
- `IF_Instr` out 32: instruction word. NOP 32'h0000_0013 when `IF_valid`=0.
- `IF_valid` out 1: presented instruction is real. 0 = bubble.

## Operation

- Internal state: `pc`, a one-entry instruction buffer, and FSM states IDLE, WAIT, HOLD, DRAIN.
- At most one imem request is outstanding. `imem_req` is never asserted in WAIT or DRAIN unless `imem_rvalid`=1 in the same cycle.
- **IDLE:** drive `imem_req`=1, `imem_addr`=`pc`, then go to WAIT.
- **WAIT, `imem_rvalid`=0:** `IF_valid`=0; stay in WAIT.
- **WAIT, `imem_rvalid`=1:** present `imem_rdata` combinationally with `IF_valid`=1.
  - If `IF_IDWrite`=1: `pc`←`pc`+4, drive `imem_req`=1 with `imem_addr`=`pc`+4 in the same cycle, stay in WAIT.
  - Else: capture `imem_rdata` into the buffer and go to HOLD.
- **HOLD:** present the buffer with `IF_valid`=1. Outputs stay stable while `IF_IDWrite`=0. When `IF_IDWrite`=1: `pc`←`pc`+4, `imem_req`=1 with `imem_addr`=`pc`+4, go to WAIT.
- **DRAIN:** a stale request is outstanding; `IF_valid`=0. When `imem_rvalid`=1: discard the data, drive `imem_req`=1 with `imem_addr`=`pc` (the redirect target), go to WAIT.
- **Redirect has highest priority in every state.** It overrides `IF_IDWrite` and any presented instruction.
  - `pc`←`redirect_pc`&~3.
  - `IF_valid` is forced to 0 that cycle.
  - If a request is outstanding and `imem_rvalid`=0 this cycle: go to DRAIN.
  - Otherwise (IDLE, HOLD, or WAIT/DRAIN with `imem_rvalid`=1): drive `imem_req`=1 with `imem_addr`=`redirect_pc`&~3 in the same cycle and go to WAIT.
  - A redirect while in DRAIN updates `pc` and remains subject to the same rule.
- **PC arithmetic:** 32-bit, wraps. 32'hFFFF_FFFC+4 = 32'h0000_0000.
- **Outputs when `IF_valid`=0:** `IF_PC`=`pc`, `IF_PCplus4`=`pc`+4, `IF_Instr`=NOP.

## Timing

- **Reset values** (registered, visible the cycle after `reset` is sampled high):
  - state IDLE, `pc`=`RESET_PC`
  - `IF_valid`=0, `IF_Instr`=NOP
  - `IF_PC`=`RESET_PC`, `IF_PCplus4`=`RESET_PC`+4
  - `imem_req`=0
- **First request:** `imem_req` asserts in the first cycle after `reset` deasserts.
- **Reset mid-operation:** the fetch is abandoned. Instruction memory shares `reset` and drops its outstanding request.
- **Throughput:**
  - 1-cycle memory, no stalls: one instruction per cycle.
  - N-cycle memory: one instruction per N cycles.
- **Redirect latency:** the first target instruction can be presented no earlier than 1 cycle after the redirect with 1-cycle memory. In DRAIN it takes the stale latency plus the new latency.
- `imem_addr` is a don't-care when `imem_req`=0.
- No combinational path from `IF_IDWrite` to `IF_Instr`, `IF_PC` or `IF_valid`. Paths from `IF_IDWrite` and `redirect` to `imem_req`/`imem_addr` are allowed.

## Structure

- Package `if_pkg` holds:
  - `if_state_t` enum (IDLE, WAIT, HOLD, DRAIN)
  - `RV_NOP` = 32'h0000_0013
  - `DEFAULT_RESET_PC`
- Sub-module `if_instr_buf`: a one-entry instruction/PC holding register with load and valid bits, reused by the stall path.
- The FSM, PC register and imem request logic live in the top level.

## Test plan

- **Reset then free-run:** 1-cycle memory, `IF_IDWrite`=1. After reset, `imem_addr` runs 0x0, 0x4, 0x8. From the second cycle onward, `IF_PC` advances by 4 every cycle with `IF_valid`=1.
- **Stall:** hold `IF_IDWrite`=0 for 3 cycles while 0x8 is presented. `IF_PC`=0x8, `IF_Instr` and `IF_PCplus4`=0xC stay stable, with no new `imem_req`. Release: the next request is 0xC.
- **Redirect with nothing outstanding:** in HOLD, `redirect`=1, `redirect_pc`=0x103. Same cycle: `imem_addr`=0x100, `IF_valid`=0. The next presented `IF_PC` is 0x100.
- **Redirect during in-flight fetch:** 3-cycle memory, redirect to 0x200 one cycle after a request to 0x10. The 0x10 data is discarded, `IF_valid` is never 1 for 0x10, and the next request is 0x200.
- **Wrap-around:** `redirect_pc`=0xFFFF_FFFC. Presented `IF_PCplus4`=0x0, and the next fetch is 0x0.
- **Reset mid-fetch:** assert `reset` while in WAIT. Outputs return to the reset values next cycle, and the first post-reset request is `RESET_PC`.
